// File: rtl/synapse317_if.sv
// Code-fetch and external-register bus of the synapse317 core.
//   code_addr  : code memory address (instruction pointer)
//   code_in    : code word at code_addr, valid when code_ready
//   code_ready : code word valid this cycle; low stalls the core
//   ext_data   : write data for external registers (muxer value)
//   ext_load   : one-hot strobe for external destinations 0x10..0x2F
// master = core side, slave = memory / external register side.
interface synapse317_if #(
  parameter int unsigned IPR_WIDTH = 12
) ();
  logic [IPR_WIDTH-1:0] code_addr;
  logic [15:0]          code_in;
  logic                 code_ready;
  logic [15:0]          ext_data;
  logic [31:0]          ext_load;

  modport master (
    output code_addr, ext_data, ext_load,
    input  code_in, code_ready
  );

  modport slave (
    input  code_addr, ext_data, ext_load,
    output code_in, code_ready
  );
endinterface

// File: rtl/synapse317.sv
// synapse317: move-machine core. Every code word is {dest[5:0], src[9:0]};
// the source is selected by the muxer and written to the destination.
// Ports:
//   sysclk, sysreset : clock, asynchronous active-high reset
//   bus              : code fetch + external register strobes (master side)
//   data_in          : read-only 16-bit input ports, port k at [16k+15:16k]
//   r_out, r_load    : general registers and their per-register write strobes
//   debug_hold       : freezes execution and ipr while high
//   stack_depth      : return-stack occupancy
//   fault            : sticky stack overflow / underflow flag
module synapse317 #(
  parameter int unsigned IPR_WIDTH       = 12,
  parameter int unsigned NUM_REGS        = 8,
  parameter int unsigned NUM_DATA_INPUTS = 4,
  parameter int unsigned STACK_DEPTH     = 8
) (
  input  logic                         sysclk,
  input  logic                         sysreset,
  synapse317_if.master                 bus,
  input  logic [16*NUM_DATA_INPUTS-1:0] data_in,
  output logic [16*NUM_REGS-1:0]       r_out,
  output logic [NUM_REGS-1:0]          r_load,
  input  logic                         debug_hold,
  output logic [6:0]                   stack_depth,
  output logic                         fault
);

  localparam int unsigned SpW      = $clog2(STACK_DEPTH);
  localparam logic [6:0]  DepthMax = 7'(STACK_DEPTH);

  logic [IPR_WIDTH-1:0] ipr_q;
  logic [15:0]          exr_q;
  logic                 exr_valid_q;  // exr holds a fetched word (clear after reset)
  logic                 skip_q;
  logic [15:0]          regs_q [NUM_REGS];
  logic [15:0]          ad0_q;
  logic                 ad0_zero_q, carry_out_q, carry_in_q, ad0_pend_q;
  logic [IPR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]       sp_q;         // next push slot
  logic [6:0]           depth_q;
  logic                 fault_q;

  logic [5:0]           dest;
  logic [9:0]           src;
  logic                 advance, execute;
  logic [3:0]           flag_bits;
  logic [15:0]          flags;
  logic [SpW-1:0]       sp_dec;
  logic [IPR_WIDTH-1:0] stack_top;
  logic [15:0]          mux;
  logic                 op_clrf, op_setf, op_br, op_bn, op_call, op_ret, is_imm, is_ext;
  logic                 sel_flag, br_take, need_skip, push, pop;
  logic [4:0]           ext_idx;
  logic [16:0]          ad0_sum;

  assign dest      = exr_q[15:10];
  assign src       = exr_q[9:0];
  assign advance   = bus.code_ready & ~debug_hold;
  assign execute   = advance & exr_valid_q & ~skip_q;
  assign flag_bits = {ad0_zero_q, carry_out_q, carry_in_q, 1'b1};
  assign flags     = {12'h000, flag_bits};
  assign sp_dec    = sp_q - SpW'(1);
  assign stack_top = (depth_q == 7'd0) ? '0 : stack_q[sp_dec];
  assign ad0_sum   = {1'b0, regs_q[0]} + {1'b0, regs_q[1]} + {16'h0000, carry_in_q};

  // Source muxer
  always_comb begin
    mux = 16'h0000;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (src == 10'(n)) mux = regs_q[n];
    end
    for (int k = 0; k < NUM_DATA_INPUTS; k++) begin
      if (src == 10'(64 + k)) mux = data_in[16*k +: 16];
    end
    if (src[9:8] == 2'b10) mux = {8'h00, src[7:0]};
    case (src)
      10'h02F: mux = 16'(stack_top);
      10'h300: mux = ad0_q;
      10'h340: mux = flags;
      10'h341: mux = {9'h000, depth_q};
      10'h3A0: mux = bus.code_in;
      default: ;
    endcase
  end

  // Destination decode
  always_comb begin
    op_clrf   = (dest == 6'h30);
    op_setf   = (dest == 6'h31);
    op_br     = (dest == 6'h38);
    op_bn     = (dest == 6'h39);
    op_call   = (dest == 6'h3E);
    op_ret    = (dest == 6'h3F);
    is_imm    = (src == 10'h3A0);
    is_ext    = (dest >= 6'h10) && (dest <= 6'h2F);
    // dest - 0x10 over 0x10..0x2F reduces to flipping bit 4
    ext_idx   = {~dest[4], dest[3:0]};
    sel_flag  = (src[3:2] == 2'b00) ? flag_bits[src[1:0]] : 1'b0;
    br_take   = (op_br & sel_flag) | (op_bn & ~sel_flag);
    need_skip = is_imm | op_br | op_bn | op_call | op_ret;
    push      = execute & op_call;
    pop       = execute & op_ret;
    r_load    = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      r_load[n] = execute && (dest == 6'(n));
    end
    bus.ext_load = (execute && is_ext) ? (32'(1) << ext_idx) : 32'h0;
  end

  assign bus.ext_data  = mux;
  assign bus.code_addr = ipr_q;
  assign stack_depth   = depth_q;
  assign fault         = fault_q;

  always_comb begin
    r_out = '0;
    for (int n = 0; n < NUM_REGS; n++) r_out[16*n +: 16] = regs_q[n];
  end

  // Fetch / sequencing
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      ipr_q       <= '0;
      exr_q       <= 16'h0000;
      exr_valid_q <= 1'b0;
      skip_q      <= 1'b0;
    end else if (advance) begin
      exr_q       <= bus.code_in;
      exr_valid_q <= 1'b1;
      skip_q      <= execute & need_skip;
      if (execute & br_take)  ipr_q <= bus.code_in[IPR_WIDTH-1:0];
      else if (push)          ipr_q <= mux[IPR_WIDTH-1:0];
      else if (pop)           ipr_q <= stack_top;
      else                    ipr_q <= ipr_q + IPR_WIDTH'(1);
    end
  end

  // Registers, adder and flags
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= 16'h0000;
      ad0_q       <= 16'h0000;
      ad0_zero_q  <= 1'b0;
      carry_out_q <= 1'b0;
      carry_in_q  <= 1'b0;
      ad0_pend_q  <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (r_load[n]) regs_q[n] <= mux;
      end
      ad0_pend_q <= r_load[0] | r_load[1];
      if (ad0_pend_q) begin
        ad0_q       <= ad0_sum[15:0];
        ad0_zero_q  <= (ad0_sum[15:0] == 16'h0000);
        carry_out_q <= ad0_sum[16];
        carry_in_q  <= ad0_sum[16];
      end
      // Explicit flag writes take priority over the adder's carry chaining
      if (execute && op_clrf && mux[1]) carry_in_q <= 1'b0;
      if (execute && op_setf && mux[1]) carry_in_q <= 1'b1;
    end
  end

  // Return stack: circular buffer, a full push overwrites the oldest entry
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      sp_q    <= '0;
      depth_q <= 7'd0;
      fault_q <= 1'b0;
    end else if (push) begin
      stack_q[sp_q] <= ipr_q;
      sp_q          <= sp_q + SpW'(1);
      if (depth_q == DepthMax) fault_q <= 1'b1;
      else                     depth_q <= depth_q + 7'd1;
    end else if (pop) begin
      if (depth_q == 7'd0) begin
        fault_q <= 1'b1;
      end else begin
        sp_q    <= sp_dec;
        depth_q <= depth_q - 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_synapse317.sv
module tb_synapse317;

  localparam logic [15:0] Nop = 16'hC800;  // dest 0x32: no effect

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic        ready = 1'b1;
  logic        debug_hold = 1'b0;
  logic [63:0] data_in = 64'hD003_D002_D001_D000;
  logic [127:0] r_out;
  logic [7:0]  r_load;
  logic [6:0]  stack_depth;
  logic        fault;
  logic [15:0] code_mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_ext;
    int          idx;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  synapse317_if #(.IPR_WIDTH(12)) bus ();

  assign bus.code_in    = code_mem[bus.code_addr[7:0]];
  assign bus.code_ready = ready;

  synapse317 #(
    .IPR_WIDTH(12), .NUM_REGS(8), .NUM_DATA_INPUTS(4), .STACK_DEPTH(2)
  ) dut (
    .sysclk(sysclk), .sysreset(sysreset), .bus(bus), .data_in(data_in),
    .r_out(r_out), .r_load(r_load), .debug_hold(debug_hold),
    .stack_depth(stack_depth), .fault(fault)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [15:0] ins(input logic [5:0] d, input logic [9:0] s);
    return {d, s};
  endfunction

  function automatic logic [15:0] rv(input int i);
    return r_out[16*i +: 16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_r(input int i, input logic [15:0] v);
    sb.push_back('{is_ext: 1'b0, idx: i, val: v});
  endtask

  task automatic exp_x(input int i, input logic [15:0] v);
    sb.push_back('{is_ext: 1'b1, idx: i, val: v});
  endtask

  // Scoreboard: every write strobe must match the next expected write
  always @(negedge sysclk) begin
    if (!sysreset && (r_load != 8'h0 || bus.ext_load != 32'h0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {24'h0, r_load, bus.ext_load}, 64'h0);
      end else begin
        exp_t e;
        logic [39:0] want;
        e = sb.pop_front();
        want = e.is_ext ? {8'h00, 32'h1 << e.idx} : {8'h1 << e.idx, 32'h0};
        chk("strobe", {24'h0, r_load, bus.ext_load}, {24'h0, want});
        chk("wdata", {48'h0, bus.ext_data}, {48'h0, e.val});
      end
    end
  end

  task automatic start_reset();
    sysreset = 1'b1;
    ready = 1'b1;
    debug_hold = 1'b0;
    sb.delete();
    for (int i = 0; i < 256; i++) code_mem[i] = Nop;
    @(posedge sysclk); #1;
  endtask

  task automatic release_reset();
    @(posedge sysclk); #1;
    sysreset = 1'b0;
  endtask

  task automatic step();
    @(posedge sysclk); #1;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin step(); n++; end
    chk(tag, 64'(sb.size()), 64'h0);
  endtask

  task automatic wait_addr(input string tag, input logic [11:0] a, input int budget);
    int n = 0;
    while (bus.code_addr !== a && n < budget) begin step(); n++; end
    chk(tag, {52'h0, bus.code_addr}, {52'h0, a});
  endtask

  task automatic wait_reg(input string tag, input int i, input logic [15:0] v, input int budget);
    int n = 0;
    while (rv(i) !== v && n < budget) begin step(); n++; end
    chk(tag, {48'h0, rv(i)}, {48'h0, v});
  endtask

  task automatic stall3(input string tag);
    logic [11:0] a;
    a = bus.code_addr;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(tag, {52'h0, bus.code_addr}, {52'h0, a});
    end
    ready = 1'b1;
  endtask

  initial begin
    // Reset state
    start_reset();
    chk("rst_addr", {52'h0, bus.code_addr}, 64'h0);
    chk("rst_regs", r_out[63:0], 64'h0);
    chk("rst_load", {24'h0, r_load, bus.ext_load}, 64'h0);
    chk("rst_depth", {57'h0, stack_depth}, 64'h0);
    chk("rst_fault", {63'h0, fault}, 64'h0);

    // Basic moves, adder, flags, input ports, unmapped source
    code_mem[0] = ins(6'h00, 10'h205);
    code_mem[1] = ins(6'h01, 10'h203);
    code_mem[2] = 16'h0000;
    code_mem[3] = ins(6'h02, 10'h300);
    code_mem[4] = ins(6'h03, 10'h340);
    code_mem[5] = ins(6'h04, 10'h041);
    code_mem[6] = ins(6'h05, 10'h043);
    code_mem[7] = ins(6'h06, 10'h3FF);
    exp_r(0, 16'h0005); exp_r(1, 16'h0003); exp_r(0, 16'h0005); exp_r(2, 16'h0008);
    exp_r(3, 16'h0001); exp_r(4, 16'hD001); exp_r(5, 16'hD003); exp_r(6, 16'h0000);
    release_reset();
    wait_sb("t1_drain", 40);
    chk("t1_r0", {48'h0, rv(0)}, 64'h5);
    chk("t1_r1", {48'h0, rv(1)}, 64'h3);
    chk("t1_ad0", {48'h0, rv(2)}, 64'h8);
    chk("t1_flags", {48'h0, rv(3)}, 64'h1);

    // imm16, skip cycle, stalls during imm16 and debug hold
    start_reset();
    code_mem[0] = ins(6'h00, 10'h3A0);
    code_mem[1] = 16'hBEEF;
    code_mem[2] = ins(6'h01, 10'h3A0);
    code_mem[3] = 16'h1234;
    code_mem[5] = ins(6'h02, 10'h2A5);
    code_mem[6] = ins(6'h03, 10'h2A6);
    exp_r(0, 16'hBEEF); exp_r(1, 16'h1234); exp_r(2, 16'h00A5); exp_r(3, 16'h00A6);
    release_reset();
    step();
    chk("t2_addr1", {52'h0, bus.code_addr}, 64'h1);
    step();
    chk("t2_skip_addr", {52'h0, bus.code_addr}, 64'h2);
    wait_addr("t2_at3", 12'h003, 10);
    stall3("t2_stall_exec");
    step();
    chk("t2_at4", {52'h0, bus.code_addr}, 64'h4);
    stall3("t2_stall_skip");
    wait_addr("t2_at6", 12'h006, 10);
    debug_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_hold_addr", {52'h0, bus.code_addr}, 64'h6);
    end
    debug_hold = 1'b0;
    wait_sb("t2_drain", 40);
    chk("t2_r0", {48'h0, rv(0)}, 64'hBEEF);
    chk("t2_r1", {48'h0, rv(1)}, 64'h1234);

    // Branches, external strobes, set/clear flags, carry chaining
    start_reset();
    code_mem[8'h00] = ins(6'h38, 10'h000);
    code_mem[8'h01] = 16'h0010;
    code_mem[8'h02] = ins(6'h00, 10'h2AA);
    code_mem[8'h10] = ins(6'h00, 10'h211);
    code_mem[8'h11] = ins(6'h39, 10'h000);
    code_mem[8'h12] = 16'h0020;
    code_mem[8'h13] = ins(6'h01, 10'h213);
    code_mem[8'h14] = ins(6'h10, 10'h2C3);
    code_mem[8'h15] = ins(6'h2F, 10'h205);
    code_mem[8'h16] = ins(6'h39, 10'h001);
    code_mem[8'h17] = 16'h0030;
    code_mem[8'h18] = ins(6'h00, 10'h2EE);
    code_mem[8'h30] = ins(6'h02, 10'h230);
    code_mem[8'h31] = ins(6'h31, 10'h202);
    code_mem[8'h32] = ins(6'h03, 10'h340);
    code_mem[8'h33] = ins(6'h30, 10'h202);
    code_mem[8'h34] = ins(6'h04, 10'h340);
    code_mem[8'h35] = ins(6'h00, 10'h2FF);
    code_mem[8'h36] = ins(6'h31, 10'h202);
    code_mem[8'h37] = ins(6'h05, 10'h340);
    code_mem[8'h38] = ins(6'h01, 10'h3A0);
    code_mem[8'h39] = 16'hFF01;
    code_mem[8'h3A] = ins(6'h06, 10'h300);
    code_mem[8'h3B] = ins(6'h07, 10'h340);
    exp_r(0, 16'h0011); exp_r(1, 16'h0013); exp_x(0, 16'h00C3); exp_x(31, 16'h0005);
    exp_r(2, 16'h0030); exp_r(3, 16'h0003); exp_r(4, 16'h0001); exp_r(0, 16'h00FF);
    exp_r(5, 16'h0003); exp_r(1, 16'hFF01); exp_r(6, 16'h0001); exp_r(7, 16'h0007);
    release_reset();
    wait_sb("t3_drain", 80);
    chk("t3_ad0_carry", {48'h0, rv(6)}, 64'h1);
    chk("t3_flags_carry", {48'h0, rv(7)}, 64'h7);

    // Return stack overflow / underflow, then reset in the middle of a call
    start_reset();
    code_mem[8'h00] = ins(6'h3E, 10'h210);
    code_mem[8'h01] = ins(6'h00, 10'h2BB);
    code_mem[8'h10] = ins(6'h3E, 10'h220);
    code_mem[8'h11] = ins(6'h03, 10'h211);
    code_mem[8'h12] = ins(6'h3F, 10'h000);
    code_mem[8'h20] = ins(6'h3E, 10'h230);
    code_mem[8'h21] = ins(6'h02, 10'h221);
    code_mem[8'h22] = ins(6'h3F, 10'h000);
    code_mem[8'h30] = ins(6'h00, 10'h341);
    code_mem[8'h31] = ins(6'h01, 10'h02F);
    code_mem[8'h32] = ins(6'h3F, 10'h000);
    exp_r(0, 16'h0002); exp_r(1, 16'h0021); exp_r(2, 16'h0021); exp_r(3, 16'h0011);
    release_reset();
    wait_addr("t4_call3", 12'h021, 30);
    chk("t4_depth_full", {57'h0, stack_depth}, 64'h2);
    chk("t4_fault_before", {63'h0, fault}, 64'h0);
    wait_reg("t4_r0_depth", 0, 16'h0002, 30);
    chk("t4_depth_ovf", {57'h0, stack_depth}, 64'h2);
    chk("t4_fault_ovf", {63'h0, fault}, 64'h1);
    wait_reg("t4_r3", 3, 16'h0011, 60);
    step();
    chk("t4_underflow_addr", {52'h0, bus.code_addr}, 64'h0);
    chk("t4_underflow_depth", {57'h0, stack_depth}, 64'h0);
    chk("t4_underflow_fault", {63'h0, fault}, 64'h1);
    wait_addr("t4_recall", 12'h001, 10);
    sysreset = 1'b1;
    #1;
    chk("t4_rst_addr", {52'h0, bus.code_addr}, 64'h0);
    chk("t4_rst_regs", r_out[63:0], 64'h0);
    chk("t4_rst_load", {24'h0, r_load, bus.ext_load}, 64'h0);
    chk("t4_rst_data", {48'h0, bus.ext_data}, 64'h0);
    chk("t4_rst_depth", {57'h0, stack_depth}, 64'h0);
    chk("t4_rst_fault", {63'h0, fault}, 64'h0);
    release_reset();
    chk("t4_rel_addr", {52'h0, bus.code_addr}, 64'h0);
    step();
    chk("t4_rel_fetch", {52'h0, bus.code_addr}, 64'h1);
    chk("t4_sb_empty", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
